// File: rtl/gcd_iter.sv
// ---------------------------------------------------------------------------
// gcd_iter
// Iterative GCD by repeated subtraction. A start request latches two unsigned
// operands. After that the block subtracts the smaller operand from the larger
// one, one subtraction per clock, until the GCD is known. The result and the
// number of subtractions are then held until the next result.
//
// Handshake: go is a request sampled on the rising edge of clk. It is accepted
// only in IDLE; go is ignored while busy=1. done is a one-cycle pulse. It goes
// high in the first cycle in which gcd_out/iters hold a new result. The FSM is
// already back in IDLE in that cycle, so go=1 during the done cycle starts the
// next computation with no dead cycle between.
//
// Ports
//   clk       : clock, rising edge
//   clr       : asynchronous, active-low reset
//   go        : start request
//   xin, yin  : operands (unsigned, WIDTH bits)
//   busy      : computation in progress
//   done      : one-cycle new-result pulse
//   gcd_out   : last computed GCD
//   iters     : subtraction count of the last computation (saturating)
//   dbg_state : current FSM state (0 = IDLE, 1 = CALC)
// ---------------------------------------------------------------------------
module gcd_iter #(
    parameter int WIDTH = 8,
    parameter int CW    = WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             go,
    input  logic [WIDTH-1:0] xin,
    input  logic [WIDTH-1:0] yin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] gcd_out,
    output logic [CW-1:0]    iters,
    output logic             dbg_state
);

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] y_q;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_inc;
    logic             res_valid;
    logic [WIDTH-1:0] res_val;

    // The result is known when either operand is zero or both are equal.
    // The zero checks come first, so gcd(0,b)=b and gcd(a,0)=a. The equal
    // check would also return the right value for gcd(0,0).
    always_comb begin
        res_valid = 1'b0;
        res_val   = x_q;
        if (x_q == '0) begin
            res_valid = 1'b1;
            res_val   = y_q;
        end else if (y_q == '0) begin
            res_valid = 1'b1;
            res_val   = x_q;
        end else if (x_q == y_q) begin
            res_valid = 1'b1;
            res_val   = x_q;
        end
    end

    // Saturating increment: the counter sticks at all-ones.
    always_comb begin
        cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_ONE;
    end

    // FSM: state register
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM: next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (go) state_nxt = CALC;
            CALC:    if (res_valid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy      = (state == CALC);
        dbg_state = state;
    end

    // Datapath. On each CALC cycle the block does exactly one thing. It either
    // records the result or subtracts the smaller operand from the larger one.
    // Subtracting the smaller from the larger means the difference never wraps.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            x_q     <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
            gcd_out <= '0;
            iters   <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (go) begin
                        x_q   <= xin;
                        y_q   <= yin;
                        cnt_q <= '0;
                    end
                end
                CALC: begin
                    if (res_valid) begin
                        gcd_out <= res_val;
                        iters   <= cnt_q;
                        done    <= 1'b1;
                    end else if (x_q < y_q) begin
                        y_q   <= y_q - x_q;
                        cnt_q <= cnt_inc;
                    end else begin
                        x_q   <= x_q - y_q;
                        cnt_q <= cnt_inc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
